// File: rtl/varredura_display_7seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex segment table, slot width
// and polarity helpers.
package pacote_display;

  localparam int LARGURA_SLOT = 2;
  localparam int NUM_SLOTS    = 4;

  // {g,f,e,d,c,b,a}, lit = 1
  localparam logic [6:0] TABELA_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] polaridade_seg(input logic [6:0] v, input logic ativo_baixo);
    return ativo_baixo ? ~v : v;
  endfunction

  function automatic logic [3:0] polaridade_an(input logic [3:0] v, input logic ativo_baixo);
    return ativo_baixo ? ~v : v;
  endfunction

  function automatic logic polaridade_bit(input logic v, input logic ativo_baixo);
    return ativo_baixo ? ~v : v;
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational 4-bit to 7-segment decode, active-high, hex digits A-F included.
module decodificador_7seg
  import pacote_display::*;
(
  input  logic [3:0] i_digito,
  output logic [6:0] o_segmentos
);

  assign o_segmentos = TABELA_SEG[i_digito];

endmodule

// File: rtl/varredura_display_7seg.sv
// 4-digit multiplexed 7-segment driver with blank interval and once-per-scan digit capture.
// Optional leading-zero blanking when SUPRIMIR_ZEROS_EN is defined.
module varredura_display_7seg
  import pacote_display::*;
#(
  parameter int CICLOS_POR_DIGITO    = 50000,
  parameter int TEMPO_APAGADO        = 16,
  parameter int ANODO_ATIVO_BAIXO    = 1,
  parameter int SEGMENTO_ATIVO_BAIXO = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] milhar,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic [3:0] pontos,
  input  logic       habilitar,
  output logic [6:0] segmentos,
  output logic       ponto_decimal,
  output logic [3:0] anodos
);

  localparam int               LP       = (CICLOS_POR_DIGITO > 1) ? $clog2(CICLOS_POR_DIGITO) : 1;
  localparam logic [LP-1:0]    FIM_CONT = LP'(CICLOS_POR_DIGITO - 1);
  localparam logic [LP-1:0]    LIM_APAG = LP'(TEMPO_APAGADO);
  localparam logic             AN_AB    = (ANODO_ATIVO_BAIXO != 0);
  localparam logic             SEG_AB   = (SEGMENTO_ATIVO_BAIXO != 0);

  logic [LP-1:0]           r_presc;
  logic [LARGURA_SLOT-1:0] r_slot;
  logic [3:0]              r_sombra_dig [NUM_SLOTS];
  logic [3:0]              r_sombra_pts;
  logic [6:0]              r_segmentos;
  logic                    r_ponto;
  logic [3:0]              r_anodos;

  logic                    w_fim;
  logic                    w_apagado;
  logic                    w_suprimido;
  logic                    w_desliga;
  logic [3:0]              w_digito;
  logic [6:0]              w_seg_dec;

  assign w_fim     = (r_presc == FIM_CONT);
  assign w_apagado = (r_presc < LIM_APAG);
  assign w_digito  = r_sombra_dig[r_slot];

  decodificador_7seg u_decod (
    .i_digito    (w_digito),
    .o_segmentos (w_seg_dec)
  );

`ifdef SUPRIMIR_ZEROS_EN
  always_comb begin
    w_suprimido = 1'b0;
    case (r_slot)
      2'd3: w_suprimido = (r_sombra_dig[3] == 4'd0);
      2'd2: w_suprimido = (r_sombra_dig[3] == 4'd0) && (r_sombra_dig[2] == 4'd0);
      2'd1: w_suprimido = (r_sombra_dig[3] == 4'd0) && (r_sombra_dig[2] == 4'd0) &&
                          (r_sombra_dig[1] == 4'd0);
      default: w_suprimido = 1'b0;
    endcase
  end
`else
  assign w_suprimido = 1'b0;
`endif

  assign w_desliga = w_apagado || !habilitar || w_suprimido;

  // Prescaler and slot counter; shadow digits reload only at the end of slot 3.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_slot       <= '0;
      r_sombra_pts <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_sombra_dig[i] <= '0;
    end else begin
      if (w_fim) begin
        r_presc <= '0;
        r_slot  <= r_slot + 2'd1;
        if (r_slot == 2'd3) begin
          r_sombra_dig[3] <= milhar;
          r_sombra_dig[2] <= centena;
          r_sombra_dig[1] <= dezena;
          r_sombra_dig[0] <= unidade;
          r_sombra_pts    <= pontos;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_anodos    <= polaridade_an(4'b0000, AN_AB);
      r_segmentos <= polaridade_seg(7'h00, SEG_AB);
      r_ponto     <= polaridade_bit(1'b0, SEG_AB);
    end else begin
      r_anodos    <= polaridade_an(w_desliga ? 4'b0000 : (4'b0001 << r_slot), AN_AB);
      r_segmentos <= polaridade_seg(w_seg_dec, SEG_AB);
      r_ponto     <= polaridade_bit(!w_desliga && r_sombra_pts[r_slot], SEG_AB);
    end
  end

  assign anodos        = r_anodos;
  assign segmentos     = r_segmentos;
  assign ponto_decimal = r_ponto;

endmodule
